button_encoder4to2: RTL



---
 rtl/button_encoder4to2_if.sv | 22 ++
 rtl/button_encoder4to2.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_encoder4to2_if.sv
// Pushbutton-side bundle: raw active-low buttons in, encoded key events out.
// The encoder itself takes the slave view.
interface button_encoder4to2_if;
  logic [3:0] btn_n;
  logic [1:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    output btn_n,
    input  key_code,
    input  key_valid,
    input  key_strobe
  );

  modport slave (
    input  btn_n,
    output key_code,
    output key_valid,
    output key_strobe
  );
endinterface

// File: rtl/button_encoder4to2.sv
// Four active-low pushbuttons: synchronize, debounce, priority-encode to a 2-bit code
// and emit one-cycle key strobes with hold-to-auto-repeat.
module button_encoder4to2 #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input logic                 clk,
  input logic                 rst_n,
  button_encoder4to2_if.slave bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_t;

  // With auto-repeat disabled a new key parks in HELD instead of arming the delay.
  localparam state_t ARM = (REPEAT_DELAY == 0) ? HELD : DELAY;

  // Returns {any, code}: lowest pressed index wins.
  function automatic logic [2:0] prio_enc(input logic [3:0] pressed);
    if (pressed[0])      return 3'b100;
    else if (pressed[1]) return 3'b101;
    else if (pressed[2]) return 3'b110;
    else if (pressed[3]) return 3'b111;
    else                 return 3'b000;
  endfunction

  logic [3:0]    sync_p0;
  logic [3:0]    sync_p1;
  logic [3:0]    deb_p2;
  logic [DW-1:0] db_cnt [4];

  // Stage 0/1: two-flop synchronizer, idles at released (all ones).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= bus.btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: per-line debounce; a line flips only after DEBOUNCE_CYCLES straight disagreements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_p2 <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic [2:0] enc;
  logic       any;
  logic [1:0] code;

  assign enc  = prio_enc(~deb_p2);
  assign any  = enc[2];
  assign code = enc[1:0];

  state_t        state, state_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [1:0]    code_p3, code_d;
  logic          vld_p3, vld_d;
  logic          stb_p3, stb_d;

  // Stage 3: key event FSM with registered outputs; code_p3 doubles as the latched code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rcnt    <= '0;
      code_p3 <= '0;
      vld_p3  <= 1'b0;
      stb_p3  <= 1'b0;
    end else begin
      state   <= state_d;
      rcnt    <= rcnt_d;
      code_p3 <= code_d;
      vld_p3  <= vld_d;
      stb_p3  <= stb_d;
    end
  end

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    code_d  = code_p3;
    vld_d   = vld_p3;
    stb_d   = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          stb_d   = 1'b1;
          code_d  = code;
          vld_d   = 1'b1;
          rcnt_d  = '0;
          state_d = ARM;
        end
      end
      DELAY, REPEAT, HELD: begin
        if (!any) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          code_d  = '0;
          rcnt_d  = '0;
        end else if (code != code_p3) begin
          // Priority key added or released: report at once and restart repeat timing.
          stb_d   = 1'b1;
          code_d  = code;
          rcnt_d  = '0;
          state_d = ARM;
        end else if (state == DELAY) begin
          if (rcnt == RD_LAST) begin
            stb_d   = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end else if (state == REPEAT) begin
          if (rcnt == RP_LAST) begin
            stb_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.key_code   = code_p3;
  assign bus.key_valid  = vld_p3;
  assign bus.key_strobe = stb_p3;

endmodule
